// File: rtl/bcd_conv_arbiter.sv
// Four-way round-robin front end for a shift-and-add-3 binary-to-BCD converter.
// A grant latches one operand, runs N_BITS shift steps and holds the result until it is accepted.
module bcd_conv_arbiter #(
  parameter int N_BITS = 16,
  parameter int N_REQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*N_BITS-1:0] bin_in,
  output logic [N_REQ-1:0]        req_ack,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_id,
  output logic [19:0]             bcd_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             r_state;
  logic [N_BITS-1:0]  r_op;
  logic [19:0]        r_acc;
  logic [4:0]         r_step;
  logic [1:0]         r_last;
  logic [1:0]         r_grant;
  logic [N_REQ-1:0]   r_ack;
  logic               r_valid;
  logic [1:0]         r_id;
  logic [19:0]        r_bcd;

  logic [N_BITS-1:0]  w_ops [N_REQ];
  logic               w_grant_vld;
  logic [1:0]         w_grant;
  logic [1:0]         w_idx;
  logic [19:0]        w_adj;
  logic [19:0]        w_next_acc;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ops
    assign w_ops[gi] = bin_in[gi*N_BITS +: N_BITS];
  end

  // Walk downward so the requester closest after r_last is the one left standing.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_idx       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = r_last + 2'(k);
      if (req[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant     = w_idx;
      end
    end
  end

  always_comb begin
    w_adj = r_acc;
    for (int d = 0; d < 5; d++) begin
      if (r_acc[4*d +: 4] > 4'd4) w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
    end
  end

  assign w_next_acc = {w_adj[18:0], r_op[N_BITS-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_acc   <= '0;
      r_step  <= '0;
      r_last  <= 2'(N_REQ - 1);
      r_grant <= '0;
      r_ack   <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_bcd   <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_grant_vld) begin
            r_op           <= w_ops[w_grant];
            r_acc          <= '0;
            r_step         <= '0;
            r_grant        <= w_grant;
            r_last         <= w_grant;
            r_ack[w_grant] <= 1'b1;
            r_state        <= SHIFT;
          end
        end
        SHIFT: begin
          r_acc  <= w_next_acc;
          r_op   <= r_op << 1;
          r_step <= r_step + 5'd1;
          if (r_step == 5'(N_BITS - 1)) begin
            r_bcd   <= w_next_acc;
            r_valid <= 1'b1;
            r_id    <= r_grant;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (r_valid && out_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ack   = r_ack;
  assign busy      = (r_state != IDLE);
  assign out_valid = r_valid;
  assign out_id    = r_id;
  assign bcd_out   = r_bcd;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: directed scenarios plus randomized conversions
// compared against a decimal-arithmetic and round-robin reference model.
module tb_bcd_conv_arbiter;
  localparam int NB = 16;
  localparam int NR = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*NB-1:0] bin_in;
  logic [NR-1:0]    req_ack;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_id;
  logic [19:0]      bcd_out;

  int errors = 0;
  int checks = 0;
  int m_last = NR - 1;

  bcd_conv_arbiter #(.N_BITS(NB), .N_REQ(NR)) dut (
    .clk(clk), .rst(rst), .req(req), .bin_in(bin_in), .req_ack(req_ack),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .bcd_out(bcd_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bcd_of(input int v);
    logic [31:0] r;
    int x;
    r = 0;
    x = v;
    for (int k = 0; k < 5; k++) begin
      r = r | (32'(x % 10) << (4 * k));
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int rr_pick(input int last, input logic [3:0] rq);
    for (int k = 1; k <= NR; k++) begin
      if (rq[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input int v);
    bin_in[i*NB +: NB] = NB'(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_ack", 32'(req_ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_id", 32'(out_id), 0);
    chk("rst_bcd", 32'(bcd_out), 0);
    @(negedge clk);
    rst = 1'b0;
    m_last = NR - 1;
  endtask

  task automatic run_conv(input logic [3:0] rq, input int delay, input bit drop);
    int g, lat, op;
    req = rq;
    out_ready = 1'b0;
    g = rr_pick(m_last, rq);
    op = int'(bin_in[g*NB +: NB]);
    @(posedge clk); #1;
    chk("ack", 32'(req_ack), 32'(1) << g);
    chk("busy_shift", 32'(busy), 1);
    m_last = g;
    if (drop) req[g] = 1'b0;
    lat = 0;
    while (!out_valid && lat < NB + 4) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) chk("ack_pulse", 32'(req_ack), 0);
    end
    chk("latency", lat, NB);
    chk("bcd", 32'(bcd_out), bcd_of(op));
    chk("id", 32'(out_id), g);
    for (int d = 0; d < delay; d++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_bcd", 32'(bcd_out), bcd_of(op));
      chk("hold_id", 32'(out_id), g);
      chk("hold_noack", 32'(req_ack), 0);
      chk("hold_busy", 32'(busy), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("accept_valid", 32'(out_valid), 0);
    chk("accept_busy", 32'(busy), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] rq;
    bin_in = '0;
    do_reset();

    // Full-scale operand from requester 0.
    set_op(0, 65535);
    run_conv(4'b0001, 0, 1'b1);

    // All four requesting, each drops after its own ack.
    do_reset();
    set_op(0, 1); set_op(1, 22); set_op(2, 333); set_op(3, 4444);
    rq = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      run_conv(rq, 0, 1'b1);
      rq = req;
    end

    // Zero operand, downstream stalls five cycles while req stays up.
    set_op(2, 0);
    run_conv(4'b0100, 5, 1'b0);

    // Two requesters held high continuously alternate.
    do_reset();
    set_op(0, 9999); set_op(2, 255);
    for (int i = 0; i < 4; i++) run_conv(4'b0101, i % 2, 1'b0);

    // Reset in the middle of SHIFT abandons the conversion.
    req = '0;
    @(negedge clk);
    set_op(0, 12345);
    req = 4'b0001;
    @(posedge clk); #1;
    req = '0;
    repeat (7) @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < NB + 2; i++) begin
      @(posedge clk); #1;
      chk("abandoned_valid", 32'(out_valid), 0);
    end
    set_op(3, 8765);
    run_conv(4'b1000, 1, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      for (int j = 0; j < NR; j++) set_op(j, int'($urandom_range(0, (1 << NB) - 1)));
      rq = 4'($urandom_range(1, 15));
      run_conv(rq, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
